fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares one `fifo` instance (IL.FL fixed-point words) between `NUM_REQ` producers. Grants the write port to one requester at a time for a burst of up to `MAX_BURST` accepted words, muxes the winner's data onto the FIFO `data_in`/`wr_en`, and stalls cleanly on `full`. Sits directly upstream of the FIFO write side; the FIFO read side is untouched.

---
 rtl/fifo_wr_arbiter.sv | 127 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin write-port arbiter that lets NUM_REQ producers share the
//   write side of one fifo of IL.FL fixed-point words. One requester holds
//   the grant at a time, for up to MAX_BURST accepted words. The winner's
//   word is muxed onto fifo_data_in/fifo_wr_en. The arbiter stalls while
//   fifo_full is high.
//
// Ports
//   clk           clock, all state updates on the rising edge
//   reset         asynchronous active-low reset
//   req           per-requester "word available"
//   req_data      requester i's word at [i*IN_BUS_WIDTH +: IN_BUS_WIDTH]
//   gnt           registered one-hot grant, all-zero when idle
//   ack           combinational: requester i's word is written at next edge
//   fifo_full     fifo full flag
//   fifo_wr_en    fifo write enable
//   fifo_data_in  fifo write data, zero when nothing is granted
//   busy          high while a grant is held
module fifo_wr_arbiter #(
  parameter int IL              = 4,
  parameter int FL              = 16,
  parameter int IN_BUS_WIDTH    = IL + FL,
  parameter int NUM_REQ         = 4,
  parameter int MAX_BURST       = 4,
  parameter int BURST_CNT_WIDTH = $clog2(MAX_BURST + 1)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*IN_BUS_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]              gnt,
  output logic [NUM_REQ-1:0]              ack,
  input  logic                            fifo_full,
  output logic                            fifo_wr_en,
  output logic [IN_BUS_WIDTH-1:0]         fifo_data_in,
  output logic                            busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                     state;
  logic [IDX_W-1:0]           last;
  logic [BURST_CNT_WIDTH-1:0] burst_cnt;

  logic                       held;
  logic                       accept;
  logic                       burst_done;
  logic                       release_gnt;
  logic                       found;
  logic [IDX_W-1:0]           winner;
  int unsigned                cand;

  // Scan last+1, last+2, ... wrapping; last itself is examined last so the
  // current or most recent holder always has the lowest priority.
  always_comb begin
    found  = 1'b0;
    winner = last;
    cand   = 0;
    for (int unsigned off = 1; off <= unsigned'(NUM_REQ); off++) begin
      cand = (32'(last) + off) % unsigned'(NUM_REQ);
      if (!found && req[cand[IDX_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[IDX_W-1:0];
      end
    end
  end

  assign held        = |(gnt & req);
  assign accept      = held & ~fifo_full;
  assign fifo_wr_en  = accept;
  assign ack         = gnt & req & {NUM_REQ{~fifo_full}};
  assign burst_done  = (burst_cnt == BURST_CNT_WIDTH'(MAX_BURST - 1));
  // Holder gave up (req low) or its last burst word goes out this edge.
  assign release_gnt = ~held | (accept & burst_done);
  assign busy        = (state == GRANT);

  always_comb begin
    fifo_data_in = '0;
    for (int unsigned i = 0; i < unsigned'(NUM_REQ); i++) begin
      if (gnt[i]) fifo_data_in = fifo_data_in | req_data[i*IN_BUS_WIDTH +: IN_BUS_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      gnt       <= '0;
      last      <= IDX_W'(NUM_REQ - 1);
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state     <= GRANT;
            gnt       <= NUM_REQ'(1) << winner;
            last      <= winner;
            burst_cnt <= '0;
          end
        end
        GRANT: begin
          if (release_gnt) begin
            // Hand over directly to the next requester, so no idle cycle
            // separates back-to-back grants.
            if (found) begin
              gnt       <= NUM_REQ'(1) << winner;
              last      <= winner;
              burst_cnt <= '0;
            end else begin
              state     <= IDLE;
              gnt       <= '0;
              burst_cnt <= '0;
            end
          end else if (accept) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

  localparam int IL = 4;
  localparam int FL = 16;
  localparam int W  = IL + FL;
  localparam int N  = 4;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   gnt;
  logic [N-1:0]   ack;
  logic           fifo_full;
  logic           fifo_wr_en;
  logic [W-1:0]   fifo_data_in;
  logic           busy;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .IL(IL),
    .FL(FL),
    .IN_BUS_WIDTH(W),
    .NUM_REQ(N),
    .MAX_BURST(MB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .req_data(req_data),
    .gnt(gnt),
    .ack(ack),
    .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en),
    .fifo_data_in(fifo_data_in),
    .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // requester side: each requester presents the head of its word queue
  logic [W-1:0] q[N][$];
  logic [N-1:0] en;
  logic [W-1:0] wrote[$];
  int           gseq[$];
  logic [N-1:0] prev_gnt;

  // reference model: who holds the grant, who held it last, words in burst
  int m_busy, m_idx, m_last, m_cnt;

  task automatic m_reset();
    m_busy = 0; m_idx = 0; m_last = N - 1; m_cnt = 0;
    prev_gnt = '0;
  endtask

  function automatic int pick(input logic [N-1:0] r, input int after);
    for (int k = 1; k <= N; k++) begin
      if (r[(after + k) % N]) return (after + k) % N;
    end
    return -1;
  endfunction

  task automatic m_step(input logic [N-1:0] r, input logic full);
    int w;
    bit rel;
    rel = 1'b0;
    if (m_busy == 0) begin
      w = pick(r, m_last);
      if (w >= 0) begin m_busy = 1; m_idx = w; m_last = w; m_cnt = 0; end
    end else begin
      if (!r[m_idx]) rel = 1'b1;
      else if (!full) begin
        m_cnt++;
        if (m_cnt == MB) rel = 1'b1;
      end
      if (rel) begin
        w = pick(r, m_last);
        if (w >= 0) begin m_idx = w; m_last = w; m_cnt = 0; end
        else m_busy = 0;
      end
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req[i] = en[i] && (q[i].size() > 0);
      req_data[i*W +: W] = (q[i].size() > 0) ? q[i][0] : '0;
    end
  endtask

  // One clock: called at posedge+1, checks at negedge, ends at next posedge+1.
  task automatic run_cycle(input int full_pct, input int en_pct, input bit refill);
    logic [N-1:0] e_gnt, e_ack;
    logic [W-1:0] e_data;
    bit acc;
    int acc_i;
    if (refill) begin
      for (int i = 0; i < N; i++)
        if (q[i].size() < 2 && $urandom_range(0, 99) < 40) q[i].push_back(W'($urandom));
    end
    if (en_pct >= 0) begin
      for (int i = 0; i < N; i++) en[i] = ($urandom_range(0, 99) < en_pct);
    end
    fifo_full = ($urandom_range(0, 99) < full_pct);
    drive();
    @(negedge clk);
    acc    = (m_busy != 0) && req[m_idx] && !fifo_full;
    e_gnt  = (m_busy != 0) ? N'(1) << m_idx : '0;
    e_ack  = acc ? N'(1) << m_idx : '0;
    e_data = (m_busy != 0) ? req_data[m_idx*W +: W] : '0;
    check("gnt", 64'(gnt), 64'(e_gnt));
    check("ack", 64'(ack), 64'(e_ack));
    check("wr_en", 64'(fifo_wr_en), 64'(acc));
    check("data_in", 64'(fifo_data_in), 64'(e_data));
    check("busy", 64'(busy), 64'(m_busy != 0));
    if (fifo_wr_en) wrote.push_back(fifo_data_in);
    if (gnt != prev_gnt && gnt != '0) begin
      for (int i = 0; i < N; i++) if (gnt[i]) gseq.push_back(i);
    end
    prev_gnt = gnt;
    acc_i = acc ? m_idx : -1;
    m_step(req, fifo_full);
    @(posedge clk);
    #1;
    if (acc_i >= 0) void'(q[acc_i].pop_front());
  endtask

  task automatic clear_queues();
    for (int i = 0; i < N; i++) q[i].delete();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    m_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  int exp_seq[$];
  int exp_fair[$];

  initial begin
    reset     = 1'b0;
    fifo_full = 1'b0;
    en        = '1;
    req       = '0;
    req_data  = '0;
    for (int i = 0; i < N; i++) q[i].push_back(W'(i + 1));
    drive();
    m_reset();

    // reset held with every requester asking
    #12;
    check("rst_gnt", 64'(gnt), 64'(0));
    check("rst_wr_en", 64'(fifo_wr_en), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_ack", 64'(ack), 64'(0));
    check("rst_data", 64'(fifo_data_in), 64'(0));
    @(posedge clk);
    #1;
    check("rst_gnt_edge", 64'(gnt), 64'(0));
    reset = 1'b1;

    // fairness: one word each, req0 re-raises later
    gseq.delete();
    for (int c = 0; c < 10; c++) begin
      if (c == 4) q[0].push_back(W'(5));
      run_cycle(0, -1, 1'b0);
    end
    exp_fair = '{0, 1, 2, 3, 0};
    check("fair_len", 64'(gseq.size()), 64'(exp_fair.size()));
    for (int i = 0; i < exp_fair.size() && i < gseq.size(); i++)
      check("fair_order", 64'(gseq[i]), 64'(exp_fair[i]));

    // burst limit and switch
    clear_queues();
    do_reset();
    for (int v = 101; v <= 106; v++) q[0].push_back(W'(v));
    q[1].push_back(W'(201));
    q[1].push_back(W'(202));
    wrote.delete();
    for (int c = 0; c < 16; c++) run_cycle(0, -1, 1'b0);
    exp_seq = '{101, 102, 103, 104, 201, 202, 105, 106};
    check("burst_len", 64'(wrote.size()), 64'(exp_seq.size()));
    for (int i = 0; i < exp_seq.size() && i < wrote.size(); i++)
      check("burst_word", 64'(wrote[i]), 64'(exp_seq[i]));

    // randomized traffic with back-pressure
    for (int c = 0; c < 3000; c++) run_cycle(25, 70, 1'b1);
    for (int c = 0; c < 1000; c++) run_cycle(10, 95, 1'b1);

    // asynchronous reset in the middle of a req1 burst
    clear_queues();
    en = '1;
    for (int v = 0; v < 6; v++) q[1].push_back(W'(300 + v));
    for (int c = 0; c < 3; c++) run_cycle(0, -1, 1'b0);
    check("mid_busy", 64'(m_busy), 64'(1));
    #2;
    reset = 1'b0;
    #1;
    check("arst_gnt", 64'(gnt), 64'(0));
    check("arst_wr_en", 64'(fifo_wr_en), 64'(0));
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_ack", 64'(ack), 64'(0));
    m_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int c = 0; c < 12; c++) run_cycle(0, -1, 1'b0);
    check("arst_drained", 64'(q[1].size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
